// File: rtl/burst_read_ctrl_if.sv
// rtl/burst_read_ctrl_if.sv - request, MRAM and capture signals of burst_read_ctrl
interface burst_read_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int BUS_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ce;
    logic [BUS_WIDTH-1:0]  mem_rdata;
    logic [BUS_WIDTH-1:0]  cap_data;
    logic                  cap_wen;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport master (
        output start, start_addr, burst_len, abort, mem_rdata, out_ready,
        input  mem_addr, mem_ce, cap_data, cap_wen, busy, done
    );

    modport slave (
        input  start, start_addr, burst_len, abort, mem_rdata, out_ready,
        output mem_addr, mem_ce, cap_data, cap_wen, busy, done
    );
endinterface

// File: rtl/burst_read_ctrl.sv
// rtl/burst_read_ctrl.sv - burst MRAM read sequencer feeding the burst data holding register
module burst_read_ctrl #(
    parameter int ADDR_WIDTH    = 16,
    parameter int BUS_WIDTH     = 16,
    parameter int LEN_WIDTH     = 8,
    parameter int ACCESS_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    burst_read_ctrl_if.slave bus
);
    localparam int WAIT_WIDTH = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = WAIT_WIDTH'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, HOLD, DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [BUS_WIDTH-1:0]  rdata_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  start_ok;
    logic                  mem_ce;
    logic                  cap_wen;
    logic                  busy;
    logic                  done;

    assign start_ok = bus.start && (bus.burst_len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_ce     = 1'b0;
        cap_wen    = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) next_state = ACCESS;
            end
            ACCESS: begin
                mem_ce = 1'b1;
                if (wait_cnt == '0) next_state = CAPTURE;
            end
            CAPTURE: begin
                cap_wen    = 1'b1;
                next_state = (remaining == LEN_WIDTH'(1)) ? DONE : HOLD;
            end
            HOLD: begin
                if (bus.out_ready) next_state = ACCESS;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Cancel overrides every other transition out of a busy state.
        if (bus.abort && (state != IDLE)) next_state = IDLE;
    end

    // Datapath updates are keyed on the chosen transition so an abort
    // automatically suppresses capture, address advance and count update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q <= '0;
            rdata_q    <= '0;
            remaining  <= '0;
            wait_cnt   <= '0;
        end else begin
            if ((state == IDLE) && (next_state == ACCESS)) begin
                mem_addr_q <= bus.start_addr;
                remaining  <= bus.burst_len;
            end
            if ((state != ACCESS) && (next_state == ACCESS)) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == ACCESS) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if ((state == ACCESS) && (next_state == CAPTURE)) begin
                rdata_q <= bus.mem_rdata;
            end
            if ((state == CAPTURE) && (next_state != IDLE)) begin
                mem_addr_q <= mem_addr_q + 1'b1;
                remaining  <= remaining - 1'b1;
            end
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_ce   = mem_ce;
    assign bus.cap_data = rdata_q;
    assign bus.cap_wen  = cap_wen;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule

// File: tb/tb_burst_read_ctrl.sv
// tb/tb_burst_read_ctrl.sv - randomized scoreboard bench for burst_read_ctrl
module tb_burst_read_ctrl;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int LW = 8;
    localparam int A  = 4;
    localparam int TL = 1024;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    int            checks = 0;
    int            errors = 0;
    word_t         exp_q[$];
    int            done_q[$];
    word_t         w;
    int            ce_run = 0;
    int            last_run = 0;
    int            words_seen = 0;
    logic [AW-1:0] ce_addr = '0;
    logic [BW-1:0] key = 16'hA5A5;

    burst_read_ctrl_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .LEN_WIDTH(LW)) bus ();

    burst_read_ctrl #(
        .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .LEN_WIDTH(LW), .ACCESS_CYCLES(A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory returns the real word only on the last cycle of an access window.
    assign bus.mem_rdata = (bus.mem_ce && (ce_run == A)) ? (bus.mem_addr ^ key)
                                                         : ~(bus.mem_addr ^ key);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            ce_run   = 0;
            last_run = 0;
        end else begin
            if (bus.mem_ce) begin
                if (ce_run > 0) check("addr_stable", 64'(bus.mem_addr), 64'(ce_addr));
                ce_addr = bus.mem_addr;
                ce_run++;
            end else if (ce_run != 0) begin
                last_run = ce_run;
                ce_run   = 0;
            end
            if (bus.cap_wen) begin
                check("access_len", 64'(last_run), 64'(A));
                words_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cap_unexpected actual=%0h required=none", bus.cap_data);
                end else begin
                    w = exp_q.pop_front();
                    check("cap_addr", 64'(bus.mem_addr), 64'(w.addr));
                    check("cap_data", 64'(bus.cap_data), 64'(w.data));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    check("done_words", 64'(words_seen), 64'(done_q.pop_front()));
                end
                words_seen = 0;
            end
        end
    end

    // Expected per-cycle {mem_ce, cap_wen, done, busy} built from the word schedule:
    // A access cycles, one capture, then hold until ready (or done after the last word).
    task automatic traced_burst(input logic [AW-1:0] addr, input int len, input int abort_in,
                                input int rst_c, input bit extra, input bit rand_ready,
                                input int low_from, input int low_to);
        bit         rdy [TL];
        logic [3:0] tl [TL];
        int         cap_c[$];
        int         c;
        int         cut;
        int         end_c;
        int         last;
        int         done_c;
        int         ncyc;
        int         abort_c;
        int         extra_c;
        logic [3:0] got;
        for (int i = 0; i < TL; i++) begin
            rdy[i] = rand_ready ? ($urandom_range(0, 2) != 0) : !((i >= low_from) && (i <= low_to));
            tl[i]  = 4'b0000;
        end
        c      = 1;
        done_c = 0;
        for (int k = 1; k <= len; k++) begin
            repeat (A) begin
                tl[c] = 4'b1001;
                c++;
            end
            tl[c] = 4'b0101;
            cap_c.push_back(c);
            c++;
            if (k == len) begin
                tl[c]  = 4'b0011;
                done_c = c;
                c++;
            end else begin
                do begin
                    tl[c] = 4'b0001;
                    c++;
                end while (!rdy[c-1] && (c < TL - 8));
            end
        end
        end_c   = c - 1;
        abort_c = (abort_in < 0) ? $urandom_range(1, end_c) : abort_in;
        cut     = (abort_c > 0) ? abort_c : (rst_c > 0) ? rst_c - 1 : TL - 1;
        for (int i = 0; i < TL; i++) if (i > cut) tl[i] = 4'b0000;
        last    = (end_c < cut) ? end_c : cut;
        ncyc    = last + 3;
        extra_c = (extra && last > 0) ? $urandom_range(1, last) : 0;
        for (int k = 0; k < cap_c.size(); k++) begin
            if (cap_c[k] <= cut) exp_q.push_back('{addr + AW'(k), (addr + AW'(k)) ^ key});
        end
        if ((done_c > 0) && (done_c <= cut)) done_q.push_back(len);
        words_seen = 0;

        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.burst_len  = LW'(len);
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.start_addr = AW'($urandom);
        bus.burst_len  = LW'($urandom);
        for (int cy = 1; cy <= ncyc; cy++) begin
            bus.out_ready = rdy[cy];
            bus.abort     = (cy == abort_c);
            if (cy == extra_c) begin
                bus.start      = 1'b1;
                bus.start_addr = AW'($urandom);
                bus.burst_len  = LW'($urandom_range(1, 255));
            end
            if (cy == rst_c) begin
                #1 rst = 1'b1;
                #1 check("rst_immediate",
                         64'({bus.mem_ce, bus.cap_wen, bus.done, bus.busy, bus.mem_addr, bus.cap_data}),
                         64'(0));
            end
            @(negedge clk);
            got = {bus.mem_ce, bus.cap_wen, bus.done, bus.busy};
            check($sformatf("trace_c%0d", cy), 64'(got), 64'(tl[cy]));
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            rst       = 1'b0;
        end
        check("sb_words_left", 64'(exp_q.size()), 64'(0));
        check("sb_done_left", 64'(done_q.size()), 64'(0));
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.burst_len  = '0;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({bus.mem_ce, bus.cap_wen, bus.done, bus.busy, bus.mem_addr, bus.cap_data}), 64'(0));
        rst = 1'b0;

        key = 16'h0040 ^ 16'hBEEF;
        traced_burst(16'h0040, 1, 0, 0, 1'b0, 1'b0, -1, -1);
        key = 16'hA5A5;
        traced_burst(16'h0010, 4, 0, 0, 1'b0, 1'b0, -1, -1);
        traced_burst(16'h0020, 2, 0, 0, 1'b0, 1'b0, 5, 7);
        traced_burst(16'hFFFE, 3, 0, 0, 1'b0, 1'b0, -1, -1);
        traced_burst(16'h1234, 0, 0, 0, 1'b0, 1'b0, -1, -1);
        traced_burst(16'h0100, 3, 0, 0, 1'b1, 1'b0, -1, -1);
        traced_burst(16'h0200, 4, 8, 0, 1'b0, 1'b0, -1, -1);
        traced_burst(16'h0200, 4, 0, 8, 1'b0, 1'b0, -1, -1);
        traced_burst(16'h0300, 4, 0, 0, 1'b0, 1'b0, -1, -1);

        repeat (40) begin
            key = BW'($urandom);
            traced_burst(AW'($urandom), $urandom_range(1, 8),
                         ($urandom_range(0, 3) == 0) ? -1 : 0, 0,
                         1'($urandom_range(0, 1)), 1'b1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/burst_read_ctrl.md
# burst_read_ctrl

Sequencer that sits directly upstream of the burst data holding register. It takes a burst request (start address, word count) and issues one MRAM read access per word, stretching each access over a fixed number of clocks. It captures each returned word and presents it on the holding register's `data_in`/`wen` pair. Between words it waits for the consumer to acknowledge the previously captured word.

## Interface
- `ADDR_WIDTH`, 16: MRAM word-address width.
- `BUS_WIDTH`, 16: data width; must equal the holding register's `BUS_WIDTH`.
- `LEN_WIDTH`, 8: width of the burst length field (max burst is 2^LEN_WIDTH-1 words).
- `ACCESS_CYCLES`, 4: clocks `mem_ce` is held per read; must be ≥1.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: burst request, sampled only in IDLE.
- `start_addr` in ADDR_WIDTH: first word address, latched with `start`.
- `burst_len` in LEN_WIDTH: number of words, latched with `start`; 0 means no burst.
- `abort` in 1: synchronous cancel, honoured in any non-IDLE state.
- `mem_addr` out ADDR_WIDTH: registered read address to MRAM.
- `mem_ce` out 1: MRAM chip enable, active-high.
- `mem_rdata` in BUS_WIDTH: MRAM read data, valid on the last ACCESS cycle.
- `cap_data` out BUS_WIDTH: captured word; connects to the holding register `data_in`.
- `cap_wen` out 1: one-cycle write strobe; connects to the holding register `wen`.
- `out_ready` in 1: consumer has taken the held word; sampled only in HOLD.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last word is captured.

## Operation
- State register has five states: IDLE, ACCESS, CAPTURE, HOLD, DONE. Outputs are Moore-decoded from state.
  - `mem_ce` is high only in ACCESS.
  - `cap_wen` is high only in CAPTURE.
  - `done` is high only in DONE.
- IDLE → ACCESS when `start` is high and `burst_len` ≠ 0.
  - Latch `mem_addr` ← `start_addr` and `remaining` ← `burst_len`.
  - Load `wait_cnt` ← ACCESS_CYCLES-1.
  - If `start` is high with `burst_len` = 0, stay in IDLE with no outputs changing.
- ACCESS: `wait_cnt` decrements each cycle.
  - When `wait_cnt` = 0: `rdata_q` ← `mem_rdata`, then go to CAPTURE.
- CAPTURE: lasts one cycle.
  - `cap_data` = `rdata_q`, `cap_wen` = 1.
  - `mem_addr` ← `mem_addr`+1, modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
  - `remaining` ← `remaining`-1.
  - If `remaining` was 1, go to DONE; otherwise go to HOLD.
- HOLD: lasts at least one cycle.
  - When `out_ready` = 1, reload `wait_cnt` and go to ACCESS; otherwise stay in HOLD.
- DONE: lasts one cycle, then goes to IDLE.
- `abort`, when high in ACCESS, CAPTURE, HOLD or DONE: next state is IDLE.
  - No `done` pulse.
  - `mem_ce` drops on the following edge.
  - `cap_wen` is not asserted on that edge.
  - `mem_addr` and `cap_data` keep their values.
  - `abort` takes priority over every other transition.
- `start` is ignored while `busy`. `out_ready` is ignored outside HOLD.
- `cap_data` holds its last value until the next CAPTURE.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_addr`, `cap_data`, `rdata_q`, `remaining`, `wait_cnt` = 0.
  - `mem_ce`, `cap_wen`, `busy`, `done` = 0.
- Reset asserted mid-burst forces the reset values immediately (asynchronous). There is no `done` pulse and no resumption.
- Cycle numbering: the `start` sampling edge is cycle 0.
  - ACCESS occupies cycles 1..A, where A = ACCESS_CYCLES.
  - CAPTURE is cycle A+1.
  - HOLD starts at cycle A+2 (minimum one cycle).
- With `out_ready` held high, each word takes A+2 cycles.
  - Word k (k = 1..N) has `cap_wen` at cycle k(A+2)-1.
  - `done` is at cycle N(A+2).
  - `busy` falls at cycle N(A+2)+1.
- The holding register samples `cap_data` on the edge closing CAPTURE, so the word is visible at its output in cycle A+2.
- `mem_addr` is stable throughout each ACCESS window and changes only on the CAPTURE edge.

## Test plan
- Single word: A=4, `start_addr`=0x0040, `burst_len`=1, `mem_rdata`=0xBEEF.
  - `mem_ce` high in cycles 1–4, `cap_wen` in cycle 5 with `cap_data`=0xBEEF, `done` in cycle 6, `busy` low in cycle 7.
- Four-word burst: `start_addr`=0x0010, `out_ready`=1, `mem_rdata` = address XOR 0xA5A5.
  - `cap_wen` in cycles 5, 11, 17, 23 with data 0xA5B5, 0xA5B4, 0xA5B7, 0xA5B6.
  - `done` in cycle 24.
- Backpressure: during a two-word burst, hold `out_ready` low for 3 cycles after the first CAPTURE.
  - HOLD lasts 3 cycles, and the second ACCESS starts one cycle after `out_ready` rises.
  - `mem_ce` stays low throughout HOLD.
- Wrap: `start_addr`=0xFFFE, `burst_len`=3.
  - `mem_addr` sequence is 0xFFFE, 0xFFFF, 0x0000, and `done` pulses once.
- Ignored requests: `start` with `burst_len`=0 leaves `busy`=0 and no `mem_ce`.
  - A second `start` pulse mid-burst does not change the address sequence or the count.
- Abort and reset: `abort` in the 2nd ACCESS cycle of word 2 of a 4-word burst gives IDLE next cycle, with no further `cap_wen` and no `done`.
  - Repeating the case with `rst` instead of `abort` gives all outputs 0 immediately.
  - A new burst afterwards completes normally.
